// File: rtl/dac_trig_sched.sv
// Multi-channel DAC trigger scheduler: per-channel delayed one-cycle triggers inside a repeating frame.
// Optional DAC_TRIG_SCHED_EXT_SYNC_EN adds ext_sync_in and an ARM state waiting for its rising edge.
module dac_trig_sched #(
  parameter int NUM_CH = 8,
  parameter int DLY_W  = 16,
  parameter int REP_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_in,
  input  logic                    stop_in,
`ifdef DAC_TRIG_SCHED_EXT_SYNC_EN
  input  logic                    ext_sync_in,
`endif
  input  logic [NUM_CH*DLY_W-1:0] cfg_delay,
  input  logic [NUM_CH-1:0]       cfg_ch_en,
  input  logic [DLY_W-1:0]        cfg_period,
  input  logic [REP_W-1:0]        cfg_repeats,
  output logic [NUM_CH-1:0]       trigger_out,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [REP_W-1:0]        frame_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN} state_t;

  state_t                         state_q, state_d;
  logic [DLY_W-1:0]               cnt_q, cnt_d;
  logic [REP_W-1:0]               frame_d;
  logic                           start_q, start_edge;
  logic                           done_d, err_d, latch;
  logic [DLY_W-1:0]               per_q;
  logic [REP_W-1:0]               rep_q;
  logic [NUM_CH-1:0]              en_q;
  logic [NUM_CH-1:0][DLY_W-1:0]   dly_q;

  assign start_edge = start_in & ~start_q;

`ifdef DAC_TRIG_SCHED_EXT_SYNC_EN
  logic ext_q, sync_edge;
  assign sync_edge = ext_sync_in & ~ext_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ext_q <= 1'b0;
    else      ext_q <= ext_sync_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      frame_idx <= '0;
      start_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_idx <= frame_d;
      start_q   <= start_in;
      busy      <= (state_d != S_IDLE);
      done      <= done_d;
      cfg_err   <= err_d;
    end
  end

  // Shadow config: only captured on an accepted start, so RUN ignores live cfg_* changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      per_q <= '0;
      rep_q <= '0;
      en_q  <= '0;
      dly_q <= '0;
    end else if (latch) begin
      per_q <= cfg_period;
      rep_q <= cfg_repeats;
      en_q  <= cfg_ch_en;
      dly_q <= cfg_delay;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_idx;
    done_d  = 1'b0;
    err_d   = 1'b0;
    latch   = 1'b0;
    if (stop_in) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      frame_d = '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_edge) begin
          if (cfg_period == '0) err_d = 1'b1;
          else begin
            latch   = 1'b1;
            cnt_d   = '0;
            frame_d = '0;
`ifdef DAC_TRIG_SCHED_EXT_SYNC_EN
            state_d = S_ARM;
`else
            state_d = S_RUN;
`endif
          end
        end
`ifdef DAC_TRIG_SCHED_EXT_SYNC_EN
        S_ARM: if (sync_edge) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
`endif
        S_RUN: begin
          if (cnt_q == per_q - DLY_W'(1)) begin
            cnt_d = '0;
            if (frame_idx == rep_q) begin
              state_d = S_IDLE;
              frame_d = '0;
              done_d  = 1'b1;
            end else begin
              frame_d = frame_idx + REP_W'(1);
            end
          end else begin
            cnt_d = cnt_q + DLY_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A delay >= period never matches cnt, so such a channel simply stays silent.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    always_ff @(posedge clk or negedge rst)
      if (!rst) trigger_out[i] <= 1'b0;
      else      trigger_out[i] <= !stop_in && (state_q == S_RUN) &&
                                  (cnt_q == dly_q[i]) && en_q[i];
  end

endmodule

// File: tb/tb_dac_trig_sched.sv
// Directed self-checking bench for dac_trig_sched; cycle c means c cycles after the start-sampling edge.
module tb_dac_trig_sched;
  localparam int NUM_CH = 8;
  localparam int DLY_W  = 16;
  localparam int REP_W  = 16;

  logic clk = 1'b0;
  logic rst;
  logic start_in, stop_in;
  logic [NUM_CH-1:0][DLY_W-1:0] dly;
  logic [NUM_CH-1:0] cfg_ch_en;
  logic [DLY_W-1:0]  cfg_period;
  logic [REP_W-1:0]  cfg_repeats;
  logic [NUM_CH-1:0] trigger_out;
  logic busy, done, cfg_err;
  logic [REP_W-1:0]  frame_idx;
`ifdef DAC_TRIG_SCHED_EXT_SYNC_EN
  logic ext_sync_in;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dac_trig_sched #(.NUM_CH(NUM_CH), .DLY_W(DLY_W), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in),
`ifdef DAC_TRIG_SCHED_EXT_SYNC_EN
    .ext_sync_in(ext_sync_in),
`endif
    .cfg_delay(dly), .cfg_ch_en(cfg_ch_en), .cfg_period(cfg_period),
    .cfg_repeats(cfg_repeats), .trigger_out(trigger_out), .busy(busy),
    .done(done), .cfg_err(cfg_err), .frame_idx(frame_idx)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; start_in = 1'b0; stop_in = 1'b0;
    dly = '0; cfg_ch_en = '0; cfg_period = '0; cfg_repeats = '0;
`ifdef DAC_TRIG_SCHED_EXT_SYNC_EN
    ext_sync_in = 1'b0;
`endif
    tick(); tick();
    chk("rst_trig", trigger_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_frame", frame_idx, 0);
    rst = 1'b1;
    tick();

`ifndef DAC_TRIG_SCHED_EXT_SYNC_EN
    // P=10 R=0, delays {0,3,9,12}, unused channels beyond the frame.
    cfg_period = 16'd10; cfg_repeats = 16'd0; cfg_ch_en = 8'hFF;
    dly = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd12, 16'd9, 16'd3, 16'd0};
    pulse_start();
    cfg_period = 16'd3;  // must not affect the running schedule
    for (int c = 1; c <= 14; c++) begin
      logic [7:0] et;
      et = 8'h00;
      if (c == 2)  et[0] = 1'b1;
      if (c == 5)  et[1] = 1'b1;
      if (c == 11) et[2] = 1'b1;
      chk($sformatf("t1_trig_c%0d", c), trigger_out, et);
      chk($sformatf("t1_busy_c%0d", c), busy, (c >= 1 && c <= 10));
      chk($sformatf("t1_done_c%0d", c), done, (c == 11));
      tick();
    end

    // P=4 R=2 d0=1: triggers 3,7,11; done 13.
    cfg_period = 16'd4; cfg_repeats = 16'd2; cfg_ch_en = 8'h01; dly = '0; dly[0] = 16'd1;
    pulse_start();
    for (int c = 1; c <= 15; c++) begin
      chk($sformatf("t2_trig_c%0d", c), trigger_out, (c == 3 || c == 7 || c == 11) ? 1 : 0);
      chk($sformatf("t2_busy_c%0d", c), busy, (c <= 12));
      chk($sformatf("t2_done_c%0d", c), done, (c == 13));
      if (c <= 12) chk($sformatf("t2_frame_c%0d", c), frame_idx, (c - 1) / 4);
      tick();
    end

    // Same config, stop sampled at edge N+6.
    pulse_start();
    for (int c = 1; c <= 14; c++) begin
      chk($sformatf("t3_trig_c%0d", c), trigger_out, (c == 3) ? 1 : 0);
      chk($sformatf("t3_busy_c%0d", c), busy, (c <= 6));
      chk($sformatf("t3_done_c%0d", c), done, 0);
      if (c >= 7) chk($sformatf("t3_frame_c%0d", c), frame_idx, 0);
      if (c == 6) begin stop_in = 1'b1; tick(); stop_in = 1'b0; end
      else tick();
    end

    // Zero period rejected.
    cfg_period = 16'd0;
    pulse_start();
    chk("t4_err", cfg_err, 1);
    chk("t4_busy", busy, 0);
    tick();
    chk("t4_err_clr", cfg_err, 0);
    chk("t4_busy2", busy, 0);

    // Restart edge in RUN ignored, held start does not retrigger.
    cfg_period = 16'd4; cfg_repeats = 16'd0; cfg_ch_en = 8'h01; dly = '0;
    pulse_start();
    for (int c = 1; c <= 9; c++) begin
      chk($sformatf("t5_trig_c%0d", c), trigger_out, (c == 2) ? 1 : 0);
      chk($sformatf("t5_busy_c%0d", c), busy, (c <= 4));
      chk($sformatf("t5_done_c%0d", c), done, (c == 5));
      if (c == 2) start_in = 1'b1;
      tick();
    end
    start_in = 1'b0;
    tick();

    // Start and stop together: stop wins.
    start_in = 1'b1; stop_in = 1'b1;
    tick();
    start_in = 1'b0; stop_in = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("t6_busy_c%0d", c), busy, 0);
      chk($sformatf("t6_trig_c%0d", c), trigger_out, 0);
      tick();
    end

    // Async reset while a trigger is high.
    cfg_period = 16'd10; dly = '0; cfg_ch_en = 8'h03;
    pulse_start();
    tick();
    chk("t7_trig_pre", trigger_out, 8'h03);
    chk("t7_busy_pre", busy, 1);
    rst = 1'b0;
    #1;
    chk("t7_trig_async", trigger_out, 0);
    chk("t7_busy_async", busy, 0);
    chk("t7_frame_async", frame_idx, 0);
    rst = 1'b1;
    tick();
    chk("t7_busy_after", busy, 0);
`else
    // ARM: busy from start, nothing until sync edge, then d=2 fires at M+4.
    cfg_period = 16'd5; cfg_repeats = 16'd0; cfg_ch_en = 8'h01; dly = '0; dly[0] = 16'd2;
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("x_arm_busy_c%0d", c), busy, 1);
      chk($sformatf("x_arm_trig_c%0d", c), trigger_out, 0);
      tick();
    end
    ext_sync_in = 1'b1;
    tick();
    ext_sync_in = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("x_trig_c%0d", c), trigger_out, (c == 4) ? 1 : 0);
      chk($sformatf("x_busy_c%0d", c), busy, (c <= 5));
      chk($sformatf("x_done_c%0d", c), done, (c == 6));
      tick();
    end
    // Stop aborts ARM.
    pulse_start();
    chk("x_arm2_busy", busy, 1);
    stop_in = 1'b1;
    tick();
    stop_in = 1'b0;
    chk("x_stop_busy", busy, 0);
    ext_sync_in = 1'b1;
    tick();
    ext_sync_in = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      chk($sformatf("x_stop_trig_c%0d", c), trigger_out, 0);
      chk($sformatf("x_stop_busy_c%0d", c), busy, 0);
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dac_trig_sched.md
# dac_trig_sched

Multi-channel trigger scheduler for the DAC playback path. It drives the per-channel `trigger_in` of each DAC playback controller with a programmable per-channel delay inside a repeating frame, so several DAC channels start waveform playback in a fixed phase relationship. It sits between the PS-controlled start/stop logic and the bank of DAC channel controllers, all in the 250 MHz RFSoC DAC clock domain.

## Interface
- `NUM_CH`, 8: number of DAC channels driven.
- `DLY_W`, 16: width of per-channel delay and frame period.
- `REP_W`, 16: width of repeat count.

Ports:
- `clk`  in  1  250 MHz clock from RFSoC IP; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `start_in`  in  1  start request; rising edge is detected internally.
- `stop_in`  in  1  abort request; level-sensitive.
- `cfg_delay`  in  NUM_CH*DLY_W  channel i delay in bits [i*DLY_W +: DLY_W], in frame cycles.
- `cfg_ch_en`  in  NUM_CH  per-channel enable.
- `cfg_period`  in  DLY_W  frame length P in cycles.
- `cfg_repeats`  in  REP_W  extra frames R; total frames = R+1.
- `trigger_out`  out  NUM_CH  one-cycle trigger per channel per frame.
- `busy`  out  1  high while frames are running.
- `done`  out  1  one-cycle pulse on normal completion.
- `cfg_err`  out  1  one-cycle pulse when a start is rejected.
- `frame_idx`  out  REP_W  index of the current frame, 0-based.

## Operation
- States: IDLE, (ARM, only with the macro), RUN.
- IDLE:
  - A `start_in` rising edge latches all `cfg_*` into shadow registers. Config changes during RUN have no effect.
  - The next state is RUN, with frame counter `cnt`=0 and `frame_idx`=0.
  - If `cfg_period`==0, the start is rejected: `cfg_err` pulses and the block stays in IDLE.
- RUN:
  - `cnt` increments every cycle.
  - At `cnt`==P-1, if `frame_idx`==R the block goes to IDLE and pulses `done`. Otherwise `cnt` wraps to 0 and `frame_idx` increments.
- Triggers:
  - `trigger_out[i]` is registered from (state==RUN && `cnt`==delay_i && en_i).
  - A delay ≥ P never fires. This is not an error.
  - Channels with equal delays fire in the same cycle.
- Stop:
  - `stop_in` high in any state forces IDLE on the next edge.
  - It clears `cnt` and `frame_idx` and suppresses the pending trigger register, so no trigger appears after the stop edge.
  - No `done` pulse is produced.
  - `stop_in` and a start edge in the same cycle: stop wins and the start is discarded.
- Start edges seen in RUN are ignored. The edge detector still tracks them, so holding `start_in` high does not restart the block after completion.
- Reset mid-operation: all state returns to reset values immediately. `trigger_out` drops asynchronously.

## Timing
- Reset values: `trigger_out`=0, `busy`=0, `done`=0, `cfg_err`=0, `frame_idx`=0, state=IDLE, `cnt`=0, start-edge history=0.
- A start edge sampled at edge N gives state RUN and `busy`=1 from cycle N+1.
- Trigger for channel i in frame k is high during cycle N+2+k*P+d_i.
- The last RUN cycle is N+(R+1)*P. In cycle N+1+(R+1)*P, `busy`=0 and `done`=1 (1 cycle).
- With P=1 and d=0, the trigger is high on R+1 consecutive cycles.
- `cfg_err` is high in cycle N+1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `DAC_TRIG_SCHED_EXT_SYNC_EN` defined:
  - Adds port `ext_sync_in` (in, 1) and state ARM.
  - An accepted start goes to ARM instead of RUN.
  - ARM waits for an `ext_sync_in` rising edge, then enters RUN with `cnt`=0. All timing figures are measured from that edge.
  - `busy` is high in ARM.
  - `stop_in` aborts ARM.
- Not defined: no `ext_sync_in` port, no ARM state. Start goes directly to RUN.

## Test plan
- Reset, then P=10, R=0, delays {0,3,9,12}, all enabled, start pulse at edge N -> `trigger_out[0..2]` at N+2, N+5, N+11; ch3 never fires; `done` at N+11; `busy` high N+1..N+10.
- P=4, R=2, d0=1 -> ch0 triggers at N+3, N+7, N+11; `frame_idx` steps 0,1,2; single `done` at N+13.
- `stop_in` raised at N+6 of the previous case -> no trigger at N+7 or later, `busy`=0 at N+7, no `done`.
- `cfg_period`=0 with start -> `cfg_err` at N+1, `busy` stays 0; a second start in RUN is ignored; `start_in` held high does not retrigger.
- Start and stop in the same cycle -> remains IDLE. Async `rst` asserted mid-RUN -> all outputs 0 immediately.
- With `DAC_TRIG_SCHED_EXT_SYNC_EN`: start, then `ext_sync_in` edge at M, d=2 -> `busy` from N+1, trigger at M+4 (P>2), no trigger before the sync edge.
